floor_call_dispatcher: RTL and testbench

//  Request side of the car-controller interface: latches per-floor call buttons, selects the next target

---
 rtl/floor_pkg.sv | 58 +++++
 rtl/floor_target_select.sv | 68 ++++++
 rtl/floor_call_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_floor_call_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// -----------------------------------------------------------------------------
// floor_pkg
//   Shared types and one-hot helpers for the floor call dispatcher.
//   Contents:
//     state_e            dispatcher FSM states (IDLE, SERVE, DWELL)
//     N_FLOORS_DEFAULT   default floor count
//     MAX_FLOORS         width of the helper vectors; N_FLOORS must not exceed it
//     is_onehot, mask_above, mask_below, lowest_set, highest_set
//   The helpers work on a fixed MAX_FLOORS-wide vector. Callers zero-extend
//   their N_FLOORS-wide vectors into it and truncate the result back.
// -----------------------------------------------------------------------------
package floor_pkg;

   localparam int N_FLOORS_DEFAULT = 4;
   localparam int MAX_FLOORS       = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DWELL = 2'd2
   } state_e;

   typedef logic [MAX_FLOORS-1:0] fvec_t;

   localparam fvec_t FVEC_ZERO = {MAX_FLOORS{1'b0}};
   localparam fvec_t FVEC_ONE  = {{(MAX_FLOORS-1){1'b0}}, 1'b1};

   // Exactly one bit set.
   function automatic logic is_onehot(input fvec_t v);
      return (v != FVEC_ZERO) && ((v & (v - FVEC_ONE)) == FVEC_ZERO);
   endfunction

   // All floors strictly above a one-hot position (zero for a zero position).
   function automatic fvec_t mask_above(input fvec_t pos);
      return ~((pos - FVEC_ONE) | pos);
   endfunction

   // All floors strictly below a one-hot position.
   function automatic fvec_t mask_below(input fvec_t pos);
      return pos - FVEC_ONE;
   endfunction

   // Isolate the lowest set bit (two's-complement trick).
   function automatic fvec_t lowest_set(input fvec_t v);
      return v & (~v + FVEC_ONE);
   endfunction

   // Isolate the highest set bit; later (higher) bits overwrite earlier ones.
   function automatic fvec_t highest_set(input fvec_t v);
      fvec_t r;
      r = FVEC_ZERO;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         r = v[i] ? (FVEC_ONE << i) : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/floor_target_select.sv
// -----------------------------------------------------------------------------
// floor_target_select
//   Combinational SCAN selector. Chooses the next floor to serve from the
//   pending calls, excluding the floor the car already sits on, and keeps
//   sweeping in the current direction while calls remain ahead of the car.
//   Ports:
//     pending      in   N_FLOORS  latched calls
//     car_floor    in   N_FLOORS  one-hot car position
//     dir_up       in   1         current sweep direction (1 = up)
//     target       out  N_FLOORS  one-hot chosen floor, zero when none
//     target_valid out  1         a target was found
//     new_dir      out  1         sweep direction to adopt with this target
// -----------------------------------------------------------------------------
module floor_target_select
   import floor_pkg::*;
#(
   parameter int N_FLOORS = N_FLOORS_DEFAULT
) (
   input  logic [N_FLOORS-1:0] pending,
   input  logic [N_FLOORS-1:0] car_floor,
   input  logic                dir_up,
   output logic [N_FLOORS-1:0] target,
   output logic                target_valid,
   output logic                new_dir
);

   fvec_t cand_s;
   fvec_t car_s;
   fvec_t above_s;
   fvec_t below_s;
   fvec_t pick_s;

   // Nearest call ahead in the sweep direction, else reverse to the nearest behind.
   always_comb begin
      cand_s  = MAX_FLOORS'(pending & ~car_floor);
      car_s   = MAX_FLOORS'(car_floor);
      above_s = cand_s & mask_above(car_s);
      below_s = cand_s & mask_below(car_s);
      pick_s  = FVEC_ZERO;
      new_dir = dir_up;
      if (dir_up) begin
         if (above_s != FVEC_ZERO) begin
            pick_s  = lowest_set(above_s);
            new_dir = 1'b1;
         end else if (below_s != FVEC_ZERO) begin
            pick_s  = highest_set(below_s);
            new_dir = 1'b0;
         end else begin
            pick_s  = FVEC_ZERO;
            new_dir = dir_up;
         end
      end else begin
         if (below_s != FVEC_ZERO) begin
            pick_s  = highest_set(below_s);
            new_dir = 1'b0;
         end else if (above_s != FVEC_ZERO) begin
            pick_s  = lowest_set(above_s);
            new_dir = 1'b1;
         end else begin
            pick_s  = FVEC_ZERO;
            new_dir = dir_up;
         end
      end
      target       = N_FLOORS'(pick_s);
      target_valid = (pick_s != FVEC_ZERO);
   end

endmodule

// File: rtl/floor_call_dispatcher.sv
// -----------------------------------------------------------------------------
// floor_call_dispatcher
//   Request side of the car-controller interface. Latches call buttons on
//   their rising edge, picks the next target with floor_target_select, drives
//   a one-hot request to the car, detects arrival, holds the door for a fixed
//   dwell, clears the served call and dispatches the next one.
//   Ports:
//     clk              in   1         system clock, posedge
//     rst              in   1         synchronous active-high reset
//     call_btn         in   N_FLOORS  synchronised button levels
//     car_floor        in   N_FLOORS  one-hot car position
//     requested_floor  out  N_FLOORS  one-hot target, zero = car holds
//     pending          out  N_FLOORS  latched unserved calls
//     door_open        out  1         high during dwell
//     dir_up           out  1         current sweep direction (1 = up)
//     car_fault        out  1         sticky: car_floor seen not one-hot
// -----------------------------------------------------------------------------
module floor_call_dispatcher
   import floor_pkg::*;
#(
   parameter int N_FLOORS     = N_FLOORS_DEFAULT,
   parameter int DWELL_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] call_btn,
   input  logic [N_FLOORS-1:0] car_floor,
   output logic [N_FLOORS-1:0] requested_floor,
   output logic [N_FLOORS-1:0] pending,
   output logic                door_open,
   output logic                dir_up,
   output logic                car_fault
);

   localparam int                  CNT_W       = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [N_FLOORS-1:0] FLOORS_NONE = {N_FLOORS{1'b0}};

   state_e              state_r;
   state_e              state_s;
   logic [N_FLOORS-1:0] btn_hist_r;
   logic [N_FLOORS-1:0] pending_r;
   logic [N_FLOORS-1:0] pending_s;
   logic [N_FLOORS-1:0] req_r;
   logic [N_FLOORS-1:0] req_s;
   logic                door_r;
   logic                door_s;
   logic                dir_r;
   logic                dir_s;
   logic                fault_r;
   logic                fault_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_s;

   logic [N_FLOORS-1:0] rise_s;
   logic [N_FLOORS-1:0] here_s;
   logic                car_ok_s;
   logic [N_FLOORS-1:0] sel_target_s;
   logic                sel_valid_s;
   logic                sel_dir_s;

   floor_target_select #(
      .N_FLOORS (N_FLOORS)
   ) u_select (
      .pending      (pending_r),
      .car_floor    (car_floor),
      .dir_up       (dir_r),
      .target       (sel_target_s),
      .target_valid (sel_valid_s),
      .new_dir      (sel_dir_s)
   );

   // Button rising edges and a trusted car position (zero when the position is corrupt).
   always_comb begin
      rise_s   = call_btn & ~btn_hist_r;
      car_ok_s = is_onehot(MAX_FLOORS'(car_floor));
      fault_s  = fault_r | ~car_ok_s;
      if (car_ok_s) begin
         here_s = car_floor;
      end else begin
         here_s = FLOORS_NONE;
      end
   end

   // FSM next state, call latch, request, dwell counter and direction.
   always_comb begin
      state_s   = state_r;
      pending_s = pending_r | rise_s;
      req_s     = req_r;
      door_s    = door_r;
      dir_s     = dir_r;
      cnt_s     = cnt_r;
      case (state_r)
         IDLE: begin
            if (car_ok_s && ((pending_r & car_floor) != FLOORS_NONE)) begin
               // Call at the car's own floor: open in place, no request issued.
               state_s   = DWELL;
               pending_s = (pending_r | rise_s) & ~car_floor;
               req_s     = FLOORS_NONE;
               door_s    = 1'b1;
               cnt_s     = CNT_ZERO;
            end else if (car_ok_s && sel_valid_s) begin
               state_s = SERVE;
               req_s   = sel_target_s;
               dir_s   = sel_dir_s;
            end else begin
               state_s = IDLE;
            end
         end
         SERVE: begin
            // Exact match against a one-hot target also rejects corrupt positions.
            if (car_floor == req_r) begin
               state_s   = DWELL;
               pending_s = (pending_r | rise_s) & ~req_r;
               req_s     = FLOORS_NONE;
               door_s    = 1'b1;
               cnt_s     = CNT_ZERO;
            end else begin
               state_s = SERVE;
            end
         end
         DWELL: begin
            // A fresh press at the open floor extends the dwell instead of queuing.
            pending_s = pending_r | (rise_s & ~here_s);
            if ((rise_s & here_s) != FLOORS_NONE) begin
               cnt_s = CNT_ZERO;
            end else if (cnt_r >= CNT_LAST) begin
               door_s = 1'b0;
               cnt_s  = CNT_ZERO;
               if (car_ok_s && sel_valid_s) begin
                  state_s = SERVE;
                  req_s   = sel_target_s;
                  dir_s   = sel_dir_s;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = FLOORS_NONE;
            door_s  = 1'b0;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         btn_hist_r <= FLOORS_NONE;
         pending_r  <= FLOORS_NONE;
         req_r      <= FLOORS_NONE;
         door_r     <= 1'b0;
         dir_r      <= 1'b1;
         fault_r    <= 1'b0;
         cnt_r      <= CNT_ZERO;
      end else begin
         state_r    <= state_s;
         btn_hist_r <= call_btn;
         pending_r  <= pending_s;
         req_r      <= req_s;
         door_r     <= door_s;
         dir_r      <= dir_s;
         fault_r    <= fault_s;
         cnt_r      <= cnt_s;
      end
   end

   assign requested_floor = req_r;
   assign pending         = pending_r;
   assign door_open       = door_r;
   assign dir_up          = dir_r;
   assign car_fault       = fault_r;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_floor_call_dispatcher
//   Directed scenarios followed by randomized button/car traffic, all checked
//   every cycle against a floor-index reference model of the dispatcher.
// -----------------------------------------------------------------------------
module tb_floor_call_dispatcher;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MD_IDLE  = 0;
   localparam int MD_SERVE = 1;
   localparam int MD_DWELL = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] call_btn;
   logic [N-1:0] car_floor;
   logic [N-1:0] requested_floor;
   logic [N-1:0] pending;
   logic         door_open;
   logic         dir_up;
   logic         car_fault;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [N-1:0] m_pend;
   logic [N-1:0] m_hist;
   int           m_req;
   int           m_mode;
   logic         m_door;
   logic         m_dir;
   logic         m_fault;
   int           m_rem;

   floor_call_dispatcher #(
      .N_FLOORS     (N),
      .DWELL_CYCLES (DW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .call_btn        (call_btn),
      .car_floor       (car_floor),
      .requested_floor (requested_floor),
      .pending         (pending),
      .door_open       (door_open),
      .dir_up          (dir_up),
      .car_fault       (car_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // SCAN choice by floor index: nearest ahead, else nearest behind.
   task automatic choose(input logic [N-1:0] p, input int c, input logic up,
                         output int t, output logic nd);
      int above;
      int below;
      above = -1;
      below = -1;
      for (int i = c + 1; i < N; i++) if (p[i] && above < 0) above = i;
      for (int i = c - 1; i >= 0; i--) if (p[i] && below < 0) below = i;
      t  = -1;
      nd = up;
      if (up) begin
         if (above >= 0) begin t = above; nd = 1'b1; end
         else if (below >= 0) begin t = below; nd = 1'b0; end
      end else begin
         if (below >= 0) begin t = below; nd = 1'b0; end
         else if (above >= 0) begin t = above; nd = 1'b1; end
      end
   endtask

   task automatic model_step(input logic r, input logic [N-1:0] btn, input logic [N-1:0] car);
      logic [N-1:0] rise;
      logic [N-1:0] old;
      logic         ok;
      logic         nd;
      int           c;
      int           t;
      if (r) begin
         m_pend = '0; m_hist = '0; m_req = -1; m_mode = MD_IDLE;
         m_door = 1'b0; m_dir = 1'b1; m_fault = 1'b0; m_rem = 0;
         return;
      end
      rise   = btn & ~m_hist;
      m_hist = btn;
      old    = m_pend;
      ok     = ($countones(car) == 1);
      c      = -1;
      for (int i = 0; i < N; i++) if (car[i]) c = i;
      if (!ok) m_fault = 1'b1;
      t  = -1;
      nd = m_dir;
      if (ok) choose(old, c, m_dir, t, nd);
      m_pend = old | rise;
      case (m_mode)
         MD_IDLE: begin
            if (ok && old[c]) begin
               m_pend[c] = 1'b0; m_mode = MD_DWELL; m_door = 1'b1; m_rem = DW;
            end else if (t >= 0) begin
               m_mode = MD_SERVE; m_req = t; m_dir = nd;
            end
         end
         MD_SERVE: begin
            if (ok && c == m_req) begin
               m_pend[c] = 1'b0; m_mode = MD_DWELL; m_req = -1; m_door = 1'b1; m_rem = DW;
            end
         end
         default: begin
            if (ok && rise[c]) begin
               m_pend[c] = old[c];
               m_rem = DW;
            end else if (m_rem <= 1) begin
               m_door = 1'b0;
               if (t >= 0) begin
                  m_mode = MD_SERVE; m_req = t; m_dir = nd;
               end else begin
                  m_mode = MD_IDLE; m_req = -1;
               end
            end else begin
               m_rem--;
            end
         end
      endcase
   endtask

   // One clock: advance the model with the current inputs, then compare all outputs.
   task automatic step();
      logic [N-1:0] exp_req;
      logic [N-1:0] one;
      one = 4'b0001;
      model_step(rst, call_btn, car_floor);
      @(posedge clk);
      #1;
      exp_req = (m_mode == MD_SERVE) ? (one << m_req) : 4'b0000;
      check_eq("req",   32'(requested_floor), 32'(exp_req));
      check_eq("pend",  32'(pending),         32'(m_pend));
      check_eq("door",  32'(door_open),       32'(m_door));
      check_eq("dir",   32'(dir_up),          32'(m_dir));
      check_eq("fault", 32'(car_fault),       32'(m_fault));
   endtask

   // Counts door-high cycles until the door closes (bounded).
   task automatic run_dwell(input int already, output int n);
      n = already;
      for (int k = 0; k < 40; k++) begin
         if (door_open !== 1'b1) break;
         step();
         if (door_open === 1'b1) n++;
      end
   endtask

   initial begin
      int           n;
      int           car_pos;
      logic [N-1:0] btn_v;
      logic [N-1:0] one;
      one       = 4'b0001;
      rst       = 1'b1;
      call_btn  = 4'b0000;
      car_floor = 4'b0001;
      step();
      step();
      check_eq("rst_req",   32'(requested_floor), 32'h0);
      check_eq("rst_pend",  32'(pending),         32'h0);
      check_eq("rst_door",  32'(door_open),       32'h0);
      check_eq("rst_dir",   32'(dir_up),          32'h1);
      check_eq("rst_fault", 32'(car_fault),       32'h0);
      rst = 1'b0;

      // 1: press floor 2 from ground
      call_btn = 4'b0100; step();
      check_eq("t1_pend", 32'(pending), 32'h4);
      check_eq("t1_req0", 32'(requested_floor), 32'h0);
      call_btn = 4'b0000; step();
      check_eq("t1_req", 32'(requested_floor), 32'h4);

      // 2: travel through floor 1, arrive at floor 2
      car_floor = 4'b0010; step();
      check_eq("t2_enroute", 32'(requested_floor), 32'h4);
      car_floor = 4'b0100; step();
      check_eq("t2_req0", 32'(requested_floor), 32'h0);
      check_eq("t2_door", 32'(door_open), 32'h1);
      check_eq("t2_pend", 32'(pending), 32'h0);
      run_dwell(1, n);
      check_eq("t2_dwell_len", 32'(n), 32'd8);

      // 3: car at floor 1 going up, calls at 3 and 0
      car_floor = 4'b0010; step();
      call_btn = 4'b1001; step();
      call_btn = 4'b0000; step();
      check_eq("t3_req_up", 32'(requested_floor), 32'h8);
      check_eq("t3_dir_up", 32'(dir_up), 32'h1);
      car_floor = 4'b0100; step();
      car_floor = 4'b1000; step();
      check_eq("t3_door", 32'(door_open), 32'h1);
      check_eq("t3_pend_low", 32'(pending), 32'h1);
      run_dwell(1, n);
      check_eq("t3_req_down", 32'(requested_floor), 32'h1);
      check_eq("t3_dir_down", 32'(dir_up), 32'h0);
      car_floor = 4'b0100; step();
      car_floor = 4'b0010; step();
      car_floor = 4'b0001; step();
      run_dwell(1, n);

      // 4: serve in place at floor 2, re-press during dwell cycle 5
      car_floor = 4'b0010; step();
      car_floor = 4'b0100; step();
      call_btn = 4'b0100; step();
      call_btn = 4'b0000; step();
      check_eq("t4_req0", 32'(requested_floor), 32'h0);
      check_eq("t4_door", 32'(door_open), 32'h1);
      n = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (door_open === 1'b1) n++;
      end
      call_btn = 4'b0100; step();
      if (door_open === 1'b1) n++;
      call_btn = 4'b0000;
      check_eq("t4_nolatch", 32'(pending), 32'h0);
      run_dwell(n, n);
      check_eq("t4_dwell_len", 32'(n), 32'd13);

      // 5: corrupt car position while serving floor 3
      call_btn = 4'b1000; step();
      call_btn = 4'b0000; step();
      check_eq("t5_req", 32'(requested_floor), 32'h8);
      car_floor = 4'b0110; step();
      check_eq("t5_fault", 32'(car_fault), 32'h1);
      check_eq("t5_hold", 32'(requested_floor), 32'h8);
      car_floor = 4'b0100; step(); step();
      car_floor = 4'b1000; step();
      check_eq("t5_sticky", 32'(car_fault), 32'h1);
      rst = 1'b1; step();
      check_eq("t5_clear", 32'(car_fault), 32'h0);
      rst = 1'b0;

      // 6: reset in dwell with calls pending at floors 1 and 3
      car_floor = 4'b0001; step();
      call_btn = 4'b0001; step();
      call_btn = 4'b0000; step();
      call_btn = 4'b1010; step();
      call_btn = 4'b0000; step();
      check_eq("t6_pend", 32'(pending), 32'ha);
      check_eq("t6_door", 32'(door_open), 32'h1);
      rst = 1'b1; step();
      check_eq("t6_req",  32'(requested_floor), 32'h0);
      check_eq("t6_pend0", 32'(pending), 32'h0);
      check_eq("t6_door0", 32'(door_open), 32'h0);
      check_eq("t6_dir",  32'(dir_up), 32'h1);
      rst = 1'b0; step(); step();
      check_eq("t6_idle", 32'(requested_floor), 32'h0);
      check_eq("t6_discard", 32'(pending), 32'h0);

      // random traffic: sparse presses, car creeps toward the model's target
      car_pos = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < N; i++) btn_v[i] = ($urandom_range(0, 9) == 0);
         call_btn = btn_v;
         if (m_mode == MD_SERVE && $urandom_range(0, 2) == 0) begin
            if (car_pos < m_req) car_pos++;
            else if (car_pos > m_req) car_pos--;
         end
         car_floor = one << car_pos;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
